td4x_core: RTL and testbench
============================

Name: td4x_core

Overview:
- Parametrised second-generation 4-bit-class accumulator CPU core: registers A/B, carry flag, program counter, output latch.
- Single-cycle fetch/execute from an internal writable program RAM.
- Adds over the first generation: configurable data width, program depth and input channel count; runtime program load; run/halt/single-step control; ADD A,B, OUT A, JC and HLT opcodes.
- Sits at board top level between switch inputs and LED outputs.

Parameters:
- DATA_W, 4, width of A, B, immediate, ALU and output; must be >= ADDR_W
- ADDR_W, 4, program counter width; program depth = 2**ADDR_W words
- IN_CH, 1, number of input channels, 1..2**DATA_W

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  level-sampled; IDLE/HALTED -> RUN
- stop  in  1  level-sampled; RUN -> HALTED
- step  in  1  in IDLE/HALTED, execute exactly one instruction at this edge
- pgm_we  in  1  program RAM write enable
- pgm_addr  in  ADDR_W  program RAM write address
- pgm_data  in  4+DATA_W  instruction word {opcode[3:0], imm[DATA_W-1:0]}
- in_data  in  IN_CH*DATA_W  input channels; channel k = bits [k*DATA_W +: DATA_W]
- out_data  out  DATA_W  output latch
- out_valid  out  1  one-cycle pulse, high the cycle after an OUT executes
- pc  out  ADDR_W  current program counter
- carry  out  1  carry flag
- running  out  1  state==RUN
- halted  out  1  state==HALTED

Behaviour:
- Reset (async, active-low): A=B=0, carry=0, pc=0, out_data=0, out_valid=0, state=IDLE. Program RAM is not cleared. RAM powers up all-zero, i.e. ADD A,0 everywhere.
- FSM:
  - IDLE: start -> RUN.
  - RUN: stop -> HALTED, no instruction executed at that edge. Executing HLT -> HALTED.
  - HALTED: start -> RUN.
  - step executes one instruction in IDLE/HALTED; the state is unchanged unless the stepped instruction is HLT, which leaves the state HALTED.
  - start and step in the same cycle: start wins, no step execution, instruction executes next edge.
- Execute: one instruction per executing edge. Fetch ram[pc] combinationally. All updates at that edge.
- ALU: {c,r} = alu_in + imm in DATA_W+1 bits. carry <= c for every ALU opcode (ADD/MOV/OUT/JMP/JNC/JC).
- Opcodes (imm = low DATA_W bits):
  - 0000 ADD A,imm: A<=A+imm.
  - 0001 MOV A,B: A<=B+imm.
  - 0010 IN A: A<=in_ch[sel], carry<=0.
  - 0011 MOV A,imm: A<=imm.
  - 0100 MOV B,A: B<=A+imm.
  - 0101 ADD B,imm: B<=B+imm.
  - 0110 IN B: B<=in_ch[sel], carry<=0.
  - 0111 MOV B,imm: B<=imm.
  - 1000 ADD A,B: A<=A+B, carry<=c of A+B (imm ignored).
  - 1001 OUT B: out<=B+imm.
  - 1010 OUT A: out<=A+imm.
  - 1011 OUT imm: out<=imm.
  - 1100 JC: pc<=imm[ADDR_W-1:0] if carry==1 (pre-instruction value) else pc+1.
  - 1101 HLT: carry and registers unchanged, pc<=pc+1.
  - 1110 JNC: jump if carry==0, else pc+1.
  - 1111 JMP: pc<=imm[ADDR_W-1:0].
  - Any non-jump opcode: pc<=pc+1.
- IN channel select: sel = imm mod 2**ceil(log2 IN_CH). If sel >= IN_CH the loaded value is 0.
- pc+1 wraps modulo 2**ADDR_W. Jump targets use imm low ADDR_W bits; upper imm bits are ignored.
- out_valid asserts for exactly one cycle after each executed OUT, including a stepped OUT.
- Program load: pgm_we honoured only in IDLE/HALTED and ignored in RUN. A write to the address being fetched in the same cycle as a step returns old data; the write lands after.
- Non-executing edges (IDLE/HALTED without step, stop edge): all architectural state holds.
- Reset asserted mid-RUN: immediate return to reset values. Program retained; restart with start re-executes from pc=0.

Test Plan:
- Load ram[0]=0011_0101 (MOV A,5), ram[1]=0000_1100 (ADD A,12), ram[2]=1101 HLT; start -> after 2 edges A=1, carry=1, pc=2; next edge halted=1, pc=3.
- Program OUT imm 1010, JMP 0 at addr 0/1; run -> out_data=1010, out_valid pulses every second cycle, pc alternates 0,1; stop -> halted, pc frozen.
- JNC loop: A=14, ram[1]=ADD A,1, ram[2]=JNC 1; run -> loops until A wraps to 0 with carry=1, falls through to pc=3; repeat with JC variant jumping only on carry.
- IN_CH=3, in_data ch0=3, ch1=9, ch2=6; IN A imm=2 -> A=6, carry=0; imm=3 -> A=0.
- In HALTED: pgm_we during RUN ignored (readback via step shows old instruction); step with start same cycle -> RUN, no double-execute; step on HLT stays HALTED, pc+1.
- DATA_W=8, ADDR_W=6: ADD A,B with A=200, B=100 -> A=44, carry=1; JMP imm=0xFF -> pc=63; reset mid-run -> all registers 0, state IDLE, RAM intact.

Source files
------------

// File: rtl/td4x_core.sv
// td4x_core: parametrised 4-bit-class accumulator CPU core.
// Single-cycle fetch/execute from an internal writable program RAM, with
// run/halt/single-step control and runtime program load.
//
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   start, stop, step   run control (level-sampled)
//   pgm_we/addr/data    program RAM write port (honoured outside RUN)
//   in_data             IN_CH input channels, DATA_W bits each
//   out_data, out_valid output latch and one-cycle "OUT executed" pulse
//   pc, carry           architectural program counter and carry flag
//   running, halted     state == RUN / state == HALTED
module td4x_core #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int IN_CH  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    step,
  input  logic                    pgm_we,
  input  logic [ADDR_W-1:0]       pgm_addr,
  input  logic [4+DATA_W-1:0]     pgm_data,
  input  logic [IN_CH*DATA_W-1:0] in_data,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  output logic [ADDR_W-1:0]       pc,
  output logic                    carry,
  output logic                    running,
  output logic                    halted
);
  localparam int IW    = 4 + DATA_W;
  localparam int DEPTH = 2**ADDR_W;
  localparam int SEL_W = (IN_CH > 1) ? $clog2(IN_CH) : 1;

  localparam logic [3:0] OP_ADD_AI = 4'b0000, OP_MOV_AB = 4'b0001,
                         OP_IN_A   = 4'b0010, OP_MOV_AI = 4'b0011,
                         OP_MOV_BA = 4'b0100, OP_ADD_BI = 4'b0101,
                         OP_IN_B   = 4'b0110, OP_MOV_BI = 4'b0111,
                         OP_ADD_AB = 4'b1000, OP_OUT_B  = 4'b1001,
                         OP_OUT_A  = 4'b1010, OP_OUT_I  = 4'b1011,
                         OP_JC     = 4'b1100, OP_HLT    = 4'b1101,
                         OP_JNC    = 4'b1110, OP_JMP    = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t              state_q, state_n;
  logic [IW-1:0]       ram [DEPTH];
  logic [DATA_W-1:0]   a_q, b_q, a_n, b_n, out_n;
  logic [ADDR_W-1:0]   pc_n;
  logic                c_n, out_valid_n;
  logic [IW-1:0]       instr;
  logic [3:0]          op;
  logic [DATA_W-1:0]   imm, alu_in, addend, alu_r, in_val;
  logic                alu_c, exec;
  logic [SEL_W-1:0]    sel;

  // Fetch is combinational; a same-edge write lands after the read.
  assign instr = ram[pc];
  assign op    = instr[IW-1 -: 4];
  assign imm   = instr[DATA_W-1:0];

  // Stop wins over execution in RUN; start wins over step outside RUN.
  assign exec = (state_q == S_RUN) ? !stop : (step && !start);

  always_ff @(posedge clock)
    if (pgm_we && state_q != S_RUN) ram[pgm_addr] <= pgm_data;

  // State register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_n;

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_RUN:   if (stop) state_n = S_HALTED;
               else if (op == OP_HLT) state_n = S_HALTED;
      default: if (start) state_n = S_RUN;
               else if (exec && op == OP_HLT) state_n = S_HALTED;
    endcase
  end

  // State outputs
  always_comb begin
    running = (state_q == S_RUN);
    halted  = (state_q == S_HALTED);
  end

  // Channel select wraps to the next power of two; unmapped channels read 0.
  assign sel = (IN_CH > 1) ? imm[SEL_W-1:0] : '0;

  always_comb begin
    in_val = '0;
    for (int k = 0; k < IN_CH; k++)
      if (int'(sel) == k) in_val = in_data[k*DATA_W +: DATA_W];
  end

  // ALU source: register operand for ADD/MOV-from/OUT-reg, zero for
  // immediate loads and jumps (so jumps always clear carry).
  always_comb begin
    alu_in = '0;
    addend = imm;
    case (op)
      OP_ADD_AI, OP_MOV_BA, OP_OUT_A: alu_in = a_q;
      OP_MOV_AB, OP_ADD_BI, OP_OUT_B: alu_in = b_q;
      OP_ADD_AB: begin alu_in = a_q; addend = b_q; end
      default:   alu_in = '0;
    endcase
    {alu_c, alu_r} = {1'b0, alu_in} + {1'b0, addend};
  end

  always_comb begin
    a_n         = a_q;
    b_n         = b_q;
    c_n         = carry;
    pc_n        = pc;
    out_n       = out_data;
    out_valid_n = 1'b0;
    if (exec) begin
      pc_n = pc + ADDR_W'(1);
      c_n  = alu_c;
      case (op)
        OP_ADD_AI, OP_MOV_AB, OP_MOV_AI, OP_ADD_AB: a_n = alu_r;
        OP_MOV_BA, OP_ADD_BI, OP_MOV_BI:            b_n = alu_r;
        OP_IN_A: begin a_n = in_val; c_n = 1'b0; end
        OP_IN_B: begin b_n = in_val; c_n = 1'b0; end
        OP_OUT_A, OP_OUT_B, OP_OUT_I: begin out_n = alu_r; out_valid_n = 1'b1; end
        OP_JC:   if (carry)  pc_n = imm[ADDR_W-1:0];
        OP_JNC:  if (!carry) pc_n = imm[ADDR_W-1:0];
        OP_JMP:  pc_n = imm[ADDR_W-1:0];
        OP_HLT:  c_n = carry;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      pc        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      a_q       <= a_n;
      b_q       <= b_n;
      carry     <= c_n;
      pc        <= pc_n;
      out_data  <= out_n;
      out_valid <= out_valid_n;
    end
endmodule

// File: tb/tb_td4x_core.sv
module tb_td4x_core;
  logic clock = 1'b0, reset = 1'b0;
  always #5 clock = ~clock;

  // u0: DATA_W=4, ADDR_W=4, IN_CH=3
  logic st0 = 0, sp0 = 0, stp0 = 0, we0 = 0;
  logic [3:0] wa0 = '0; logic [7:0] wd0 = '0; logic [11:0] ind0 = {4'd6, 4'd9, 4'd3};
  logic [3:0] od0, pc0; logic ov0, c0, run0, hlt0;
  // u1: DATA_W=8, ADDR_W=6, IN_CH=1
  logic st1 = 0, sp1 = 0, stp1 = 0, we1 = 0;
  logic [5:0] wa1 = '0; logic [11:0] wd1 = '0; logic [7:0] ind1 = '0;
  logic [7:0] od1; logic [5:0] pc1; logic ov1, c1, run1, hlt1;

  int checks = 0, errors = 0;

  td4x_core #(.DATA_W(4), .ADDR_W(4), .IN_CH(3)) u0 (
    .clock(clock), .reset(reset), .start(st0), .stop(sp0), .step(stp0),
    .pgm_we(we0), .pgm_addr(wa0), .pgm_data(wd0), .in_data(ind0),
    .out_data(od0), .out_valid(ov0), .pc(pc0), .carry(c0),
    .running(run0), .halted(hlt0));

  td4x_core #(.DATA_W(8), .ADDR_W(6), .IN_CH(1)) u1 (
    .clock(clock), .reset(reset), .start(st1), .stop(sp1), .step(stp1),
    .pgm_we(we1), .pgm_addr(wa1), .pgm_data(wd1), .in_data(ind1),
    .out_data(od1), .out_valid(ov1), .pc(pc1), .carry(c1),
    .running(run1), .halted(hlt1));

  task automatic tick(); @(posedge clock); #1; endtask
  task automatic do_reset(); reset = 0; tick(); tick(); reset = 1; endtask
  task automatic load0(input logic [3:0] a, input logic [7:0] d);
    we0 = 1; wa0 = a; wd0 = d; tick(); we0 = 0;
  endtask
  task automatic load1(input logic [5:0] a, input logic [11:0] d);
    we1 = 1; wa1 = a; wd1 = d; tick(); we1 = 0;
  endtask
  task automatic start0(); st0 = 1; tick(); st0 = 0; endtask
  task automatic step0();  stp0 = 1; tick(); stp0 = 0; endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc0 !== 4'd0 || c0 !== 1'b0 || od0 !== 4'd0 || ov0 !== 1'b0) begin errors++; $display("FAIL reset_regs0 pc=%0d c=%0b out=%0d ov=%0b want 0", pc0, c0, od0, ov0); end
    checks++; if (run0 !== 1'b0 || hlt0 !== 1'b0) begin errors++; $display("FAIL reset_state0 run=%0b hlt=%0b want 0 0", run0, hlt0); end
    checks++; if (pc1 !== 6'd0 || c1 !== 1'b0 || od1 !== 8'd0 || run1 !== 1'b0) begin errors++; $display("FAIL reset_regs1 pc=%0d c=%0b out=%0d run=%0b want 0", pc1, c1, od1, run1); end
  endtask

  task automatic test_basic();
    load0(0, 8'h35); load0(1, 8'h0C); load0(2, 8'hD0); load0(3, 8'hA0);
    start0();
    checks++; if (run0 !== 1'b1 || pc0 !== 4'd0) begin errors++; $display("FAIL basic_start run=%0b pc=%0d want 1 0", run0, pc0); end
    tick(); tick();
    checks++; if (pc0 !== 4'd2 || c0 !== 1'b1) begin errors++; $display("FAIL basic_add pc=%0d c=%0b want 2 1", pc0, c0); end
    tick();
    checks++; if (hlt0 !== 1'b1 || run0 !== 1'b0 || pc0 !== 4'd3) begin errors++; $display("FAIL basic_hlt hlt=%0b run=%0b pc=%0d want 1 0 3", hlt0, run0, pc0); end
    step0();
    checks++; if (od0 !== 4'd1 || ov0 !== 1'b1 || c0 !== 1'b0 || pc0 !== 4'd4) begin errors++; $display("FAIL basic_out_a out=%0d ov=%0b c=%0b pc=%0d want 1 1 0 4", od0, ov0, c0, pc0); end
    tick();
    checks++; if (ov0 !== 1'b0 || pc0 !== 4'd4 || hlt0 !== 1'b1) begin errors++; $display("FAIL basic_hold ov=%0b pc=%0d hlt=%0b want 0 4 1", ov0, pc0, hlt0); end
  endtask

  task automatic test_out_jmp();
    load0(0, 8'hBA); load0(1, 8'hF0);
    do_reset(); start0();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc0 !== 4'd1 || ov0 !== 1'b1 || od0 !== 4'hA) begin errors++; $display("FAIL outjmp_out%0d pc=%0d ov=%0b out=%0h want 1 1 a", i, pc0, ov0, od0); end
      tick();
      checks++; if (pc0 !== 4'd0 || ov0 !== 1'b0) begin errors++; $display("FAIL outjmp_jmp%0d pc=%0d ov=%0b want 0 0", i, pc0, ov0); end
    end
    sp0 = 1; tick();
    checks++; if (hlt0 !== 1'b1 || pc0 !== 4'd0 || ov0 !== 1'b0) begin errors++; $display("FAIL outjmp_stop hlt=%0b pc=%0d ov=%0b want 1 0 0", hlt0, pc0, ov0); end
    sp0 = 0; tick();
    checks++; if (pc0 !== 4'd0 || od0 !== 4'hA) begin errors++; $display("FAIL outjmp_frozen pc=%0d out=%0h want 0 a", pc0, od0); end
  endtask

  task automatic test_jnc();
    do_reset();
    load0(0, 8'h3E); load0(1, 8'h01); load0(2, 8'hE1); load0(3, 8'hD0); load0(4, 8'hA0);
    start0();
    tick(); tick(); tick();
    checks++; if (pc0 !== 4'd1 || c0 !== 1'b0) begin errors++; $display("FAIL jnc_taken pc=%0d c=%0b want 1 0", pc0, c0); end
    tick();
    checks++; if (pc0 !== 4'd2 || c0 !== 1'b1) begin errors++; $display("FAIL jnc_wrap pc=%0d c=%0b want 2 1", pc0, c0); end
    tick();
    checks++; if (pc0 !== 4'd3 || c0 !== 1'b0) begin errors++; $display("FAIL jnc_fall pc=%0d c=%0b want 3 0", pc0, c0); end
    tick();
    checks++; if (hlt0 !== 1'b1 || pc0 !== 4'd4) begin errors++; $display("FAIL jnc_hlt hlt=%0b pc=%0d want 1 4", hlt0, pc0); end
    step0();
    checks++; if (od0 !== 4'd0 || ov0 !== 1'b1) begin errors++; $display("FAIL jnc_a out=%0d ov=%0b want 0 1", od0, ov0); end
  endtask

  task automatic test_jc();
    do_reset();
    load0(0, 8'h3E); load0(1, 8'h01); load0(2, 8'hC4); load0(3, 8'hF1); load0(4, 8'hD0);
    start0();
    tick(); tick(); tick();
    checks++; if (pc0 !== 4'd3) begin errors++; $display("FAIL jc_not_taken pc=%0d want 3", pc0); end
    tick(); tick();
    checks++; if (pc0 !== 4'd2 || c0 !== 1'b1) begin errors++; $display("FAIL jc_wrap pc=%0d c=%0b want 2 1", pc0, c0); end
    tick();
    checks++; if (pc0 !== 4'd4 || c0 !== 1'b0) begin errors++; $display("FAIL jc_taken pc=%0d c=%0b want 4 0", pc0, c0); end
    tick();
    checks++; if (hlt0 !== 1'b1 || pc0 !== 4'd5) begin errors++; $display("FAIL jc_hlt hlt=%0b pc=%0d want 1 5", hlt0, pc0); end
  endtask

  task automatic test_in();
    do_reset();
    load0(0, 8'h3F); load0(1, 8'h01); load0(2, 8'h22); load0(3, 8'hA0);
    load0(4, 8'h23); load0(5, 8'hA0); load0(6, 8'h61); load0(7, 8'h90);
    load0(8, 8'h26); load0(9, 8'hA1); load0(10, 8'hD0);
    step0(); step0();
    checks++; if (c0 !== 1'b1 || pc0 !== 4'd2 || run0 !== 1'b0 || hlt0 !== 1'b0) begin errors++; $display("FAIL in_pre c=%0b pc=%0d run=%0b hlt=%0b want 1 2 0 0", c0, pc0, run0, hlt0); end
    step0();
    checks++; if (c0 !== 1'b0) begin errors++; $display("FAIL in_clr_c c=%0b want 0", c0); end
    step0();
    checks++; if (od0 !== 4'd6 || ov0 !== 1'b1) begin errors++; $display("FAIL in_ch2 out=%0d ov=%0b want 6 1", od0, ov0); end
    step0(); step0();
    checks++; if (od0 !== 4'd0) begin errors++; $display("FAIL in_unmapped out=%0d want 0", od0); end
    step0(); step0();
    checks++; if (od0 !== 4'd9) begin errors++; $display("FAIL in_b_ch1 out=%0d want 9", od0); end
    step0(); step0();
    checks++; if (od0 !== 4'd7) begin errors++; $display("FAIL in_sel_wrap out=%0d want 7", od0); end
    step0();
    checks++; if (hlt0 !== 1'b1 || pc0 !== 4'd11) begin errors++; $display("FAIL in_step_hlt hlt=%0b pc=%0d want 1 11", hlt0, pc0); end
  endtask

  task automatic test_ctrl();
    do_reset();
    load0(0, 8'hB5); load0(1, 8'hB6); load0(2, 8'hF0);
    start0(); tick(); tick();
    we0 = 1; wa0 = 0; wd0 = 8'hB9; tick(); we0 = 0;
    sp0 = 1; tick(); sp0 = 0;
    do_reset();
    step0();
    checks++; if (od0 !== 4'd5 || pc0 !== 4'd1) begin errors++; $display("FAIL ctrl_we_run_ignored out=%0d pc=%0d want 5 1", od0, pc0); end
    st0 = 1; stp0 = 1; tick(); st0 = 0; stp0 = 0;
    checks++; if (run0 !== 1'b1 || pc0 !== 4'd1 || ov0 !== 1'b0) begin errors++; $display("FAIL ctrl_start_step run=%0b pc=%0d ov=%0b want 1 1 0", run0, pc0, ov0); end
    tick();
    checks++; if (od0 !== 4'd6 || ov0 !== 1'b1 || pc0 !== 4'd2) begin errors++; $display("FAIL ctrl_first_exec out=%0d ov=%0b pc=%0d want 6 1 2", od0, ov0, pc0); end
    sp0 = 1; tick(); sp0 = 0;
    we0 = 1; wa0 = 2; wd0 = 8'hB3; stp0 = 1; tick(); we0 = 0; stp0 = 0;
    checks++; if (pc0 !== 4'd0 || ov0 !== 1'b0 || hlt0 !== 1'b1) begin errors++; $display("FAIL ctrl_write_step_old pc=%0d ov=%0b hlt=%0b want 0 0 1", pc0, ov0, hlt0); end
    step0(); step0(); step0();
    checks++; if (od0 !== 4'd3 || pc0 !== 4'd3) begin errors++; $display("FAIL ctrl_write_landed out=%0d pc=%0d want 3 3", od0, pc0); end
    load0(3, 8'hD0);
    step0();
    checks++; if (hlt0 !== 1'b1 || pc0 !== 4'd4 || od0 !== 4'd3) begin errors++; $display("FAIL ctrl_step_hlt hlt=%0b pc=%0d out=%0d want 1 4 3", hlt0, pc0, od0); end
  endtask

  task automatic test_wide();
    do_reset();
    load1(0, 12'h3C8); load1(1, 12'h764); load1(2, 12'h800);
    load1(3, 12'hA00); load1(4, 12'hFFF); load1(63, 12'hD00);
    st1 = 1; tick(); st1 = 0;
    tick(); tick(); tick();
    checks++; if (c1 !== 1'b1 || pc1 !== 6'd3) begin errors++; $display("FAIL wide_add_ab c=%0b pc=%0d want 1 3", c1, pc1); end
    tick();
    checks++; if (od1 !== 8'd44 || ov1 !== 1'b1 || c1 !== 1'b0) begin errors++; $display("FAIL wide_out out=%0d ov=%0b c=%0b want 44 1 0", od1, ov1, c1); end
    tick();
    checks++; if (pc1 !== 6'd63) begin errors++; $display("FAIL wide_jmp pc=%0d want 63", pc1); end
    tick();
    checks++; if (hlt1 !== 1'b1 || pc1 !== 6'd0) begin errors++; $display("FAIL wide_pc_wrap hlt=%0b pc=%0d want 1 0", hlt1, pc1); end
    st1 = 1; tick(); st1 = 0;
    tick(); tick(); tick();
    reset = 0; #1;
    checks++; if (pc1 !== 6'd0 || c1 !== 1'b0 || od1 !== 8'd0 || ov1 !== 1'b0 || run1 !== 1'b0 || hlt1 !== 1'b0) begin errors++; $display("FAIL wide_async_reset pc=%0d c=%0b out=%0d ov=%0b run=%0b hlt=%0b want all 0", pc1, c1, od1, ov1, run1, hlt1); end
    tick(); reset = 1;
    st1 = 1; tick(); st1 = 0;
    tick(); tick(); tick(); tick();
    checks++; if (od1 !== 8'd44 || ov1 !== 1'b1 || pc1 !== 6'd4) begin errors++; $display("FAIL wide_ram_kept out=%0d ov=%0b pc=%0d want 44 1 4", od1, ov1, pc1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_out_jmp();
    test_jnc();
    test_jc();
    test_in();
    test_ctrl();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
